// File: rtl/fpga_status_pkg.sv
// Shared types and constants for the FPGA self-check status monitor.
package fpga_status_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } status_t;

  localparam int unsigned LED_RUN   = 3;
  localparam int unsigned LED_OK    = 2;
  localparam int unsigned LED_FAIL  = 1;
  localparam int unsigned LED_PWR   = 0;

  localparam int unsigned WRCOUNT_W = 16;

endpackage

// File: rtl/fpga_status_monitor_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count enabled events, hold at max, synchronous clear wins over enable.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/fpga_status_monitor.sv
// Watches core stores and decides pass/fail of the test program; drives the
// board LEDs {running, succeeded, failed, power}.
//
//   state | meaning
//   IDLE  | one cycle after reset release, stores ignored
//   RUN   | program executing, counters running
//   PASS  | success store seen, terminal until reset
//   FAIL  | wrong data at success address or timeout, terminal until reset
module fpga_status_monitor
  import fpga_status_pkg::*;
#(
  parameter logic [31:0] SUCCESS_ADR  = 32'h0000_0054,
  parameter logic [31:0] SUCCESS_DATA = 32'h0000_0007,
  parameter int unsigned TIMEOUT_W    = 24,
  parameter int unsigned BLINK_W      = 22
) (
  input  logic                 ph1,
  input  logic                 reset,
  input  logic                 memwrite,
  input  logic [31:0]          dataadr,
  input  logic [31:0]          writedata,
  output logic [3:0]           leds,
  output logic                 done,
  output logic                 passed,
  output logic [WRCOUNT_W-1:0] wrcount
);

  status_t              state, state_next;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [BLINK_W-1:0]   blink_q, blink_next;
  logic                 decisive;
  logic                 tmo_hit;
  logic [3:0]           leds_next;
  logic                 done_next, passed_next;

  assign decisive = memwrite && (dataadr == SUCCESS_ADR);
  assign tmo_hit  = &tmo_q;

  // Blink value the LED decode will see after this edge; only moves in RUN.
  assign blink_next = (state == RUN) ? blink_q + BLINK_W'(1) : blink_q;

  // State register.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state: a decisive store takes priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = RUN;
      RUN: begin
        if (decisive)
          state_next = (writedata == SUCCESS_DATA) ? PASS : FAIL;
        else if (tmo_hit)
          state_next = FAIL;
      end
      default: state_next = state;
    endcase
  end

  // Output decode from next-state so the registered outputs track the state.
  always_comb begin
    leds_next          = '0;
    leds_next[LED_PWR] = 1'b1;
    done_next          = 1'b0;
    passed_next        = 1'b0;
    case (state_next)
      RUN:  leds_next[LED_RUN] = ~blink_next[BLINK_W-1];
      PASS: begin
        leds_next[LED_OK] = 1'b1;
        done_next         = 1'b1;
        passed_next       = 1'b1;
      end
      FAIL: begin
        leds_next[LED_FAIL] = 1'b1;
        done_next           = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs; power LED stays lit through reset.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      leds   <= 4'b0001;
      done   <= 1'b0;
      passed <= 1'b0;
    end else begin
      leds   <= leds_next;
      done   <= done_next;
      passed <= passed_next;
    end
  end

  // Timeout and blink wrap counters, frozen outside RUN.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      tmo_q   <= '0;
      blink_q <= '0;
    end else begin
      blink_q <= blink_next;
      if (state == RUN)
        tmo_q <= tmo_q + TIMEOUT_W'(1);
    end
  end

  sat_counter #(
    .WIDTH (WRCOUNT_W)
  ) u_wrcount (
    .ph1   (ph1),
    .reset (reset),
    .en    ((state == RUN) && memwrite),
    .clr   (1'b0),
    .count (wrcount)
  );

endmodule

// File: tb/tb_fpga_status_monitor.sv
// Directed bench for fpga_status_monitor (short timeout instance plus a long
// timeout instance for store-count saturation).
module tb_fpga_status_monitor;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic        reset2 = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;

  logic [3:0]  leds, leds2;
  logic        done, done2, passed, passed2;
  logic [15:0] wrcount, wrcount2;

  int n_pass = 0;
  int n_total = 0;

  always #5 ph1 = ~ph1;

  fpga_status_monitor #(.TIMEOUT_W(8), .BLINK_W(3)) dut (
    .ph1(ph1), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .leds(leds), .done(done), .passed(passed),
    .wrcount(wrcount)
  );

  fpga_status_monitor #(.TIMEOUT_W(24), .BLINK_W(3)) dut2 (
    .ph1(ph1), .reset(reset2), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .leds(leds2), .done(done2), .passed(passed2),
    .wrcount(wrcount2)
  );

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    memwrite  = 1'b1;
    dataadr   = adr;
    writedata = data;
    tick();
    memwrite  = 1'b0;
  endtask

  // Leaves the bench just after an edge with reset low; next edge is edge 1.
  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_total++; if (leds !== 4'b0001) $display("FAIL reset_leds: got %b want 0001", leds); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (passed !== 1'b0) $display("FAIL reset_passed: got %b want 0", passed); else n_pass++;
    n_total++; if (wrcount !== 16'h0) $display("FAIL reset_wrcount: got %h want 0000", wrcount); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (leds !== 4'b1001) $display("FAIL run_entry_leds: got %b want 1001", leds); else n_pass++;
    store(32'h10, 32'h1);
    n_total++; if (wrcount !== 16'h1) $display("FAIL run_first_store: got %h want 0001", wrcount); else n_pass++;
    #3;
    reset = 1'b1;
    #1;
    n_total++; if (leds !== 4'b0001) $display("FAIL async_reset_leds: got %b want 0001", leds); else n_pass++;
    n_total++; if (wrcount !== 16'h0) $display("FAIL async_reset_wrcount: got %h want 0000", wrcount); else n_pass++;
  endtask

  task automatic test_pass();
    restart();
    tick();
    repeat (3) store(32'h10, 32'h1234);
    n_total++; if (wrcount !== 16'h3) $display("FAIL pass_pre_wrcount: got %h want 0003", wrcount); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL pass_pre_done: got %b want 0", done); else n_pass++;
    store(32'h54, 32'h7);
    n_total++; if (wrcount !== 16'h4) $display("FAIL pass_wrcount: got %h want 0004", wrcount); else n_pass++;
    n_total++; if (leds !== 4'b0101) $display("FAIL pass_leds: got %b want 0101", leds); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL pass_done: got %b want 1", done); else n_pass++;
    n_total++; if (passed !== 1'b1) $display("FAIL pass_passed: got %b want 1", passed); else n_pass++;
    store(32'h54, 32'h5);
    tick();
    n_total++; if (wrcount !== 16'h4) $display("FAIL pass_frozen_wrcount: got %h want 0004", wrcount); else n_pass++;
    n_total++; if (leds !== 4'b0101) $display("FAIL pass_frozen_leds: got %b want 0101", leds); else n_pass++;
    n_total++; if (passed !== 1'b1) $display("FAIL pass_frozen_passed: got %b want 1", passed); else n_pass++;
  endtask

  task automatic test_fail_data();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    memwrite  = 1'b1;
    dataadr   = 32'h54;
    writedata = 32'h6;
    tick();
    memwrite  = 1'b0;
    n_total++; if (wrcount !== 16'h0) $display("FAIL idle_store_ignored: got %h want 0000", wrcount); else n_pass++;
    n_total++; if (leds !== 4'b1001) $display("FAIL idle_store_leds: got %b want 1001", leds); else n_pass++;
    store(32'h54, 32'h6);
    n_total++; if (leds !== 4'b0011) $display("FAIL faildata_leds: got %b want 0011", leds); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL faildata_done: got %b want 1", done); else n_pass++;
    n_total++; if (passed !== 1'b0) $display("FAIL faildata_passed: got %b want 0", passed); else n_pass++;
    n_total++; if (wrcount !== 16'h1) $display("FAIL faildata_wrcount: got %h want 0001", wrcount); else n_pass++;
  endtask

  task automatic test_timeout();
    logic exp_run;
    restart();
    for (int e = 1; e <= 256; e++) begin
      tick();
      if (e <= 16) begin
        exp_run = (((e - 1) / 4) % 2) == 0;
        n_total++;
        if (leds !== {exp_run, 3'b001})
          $display("FAIL blink_edge%0d: got %b want %b", e, leds, {exp_run, 3'b001});
        else n_pass++;
      end
    end
    n_total++; if (done !== 1'b0) $display("FAIL timeout_early: done=%b at edge 256 want 0", done); else n_pass++;
    tick();
    n_total++; if (leds !== 4'b0011) $display("FAIL timeout_leds: got %b want 0011", leds); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL timeout_done: got %b want 1", done); else n_pass++;
    n_total++; if (passed !== 1'b0) $display("FAIL timeout_passed: got %b want 0", passed); else n_pass++;
  endtask

  task automatic test_simultaneous();
    restart();
    repeat (256) tick();
    n_total++; if (done !== 1'b0) $display("FAIL simul_pre_done: got %b want 0", done); else n_pass++;
    store(32'h54, 32'h7);
    n_total++; if (leds !== 4'b0101) $display("FAIL simul_leds: got %b want 0101", leds); else n_pass++;
    n_total++; if (passed !== 1'b1) $display("FAIL simul_passed: got %b want 1", passed); else n_pass++;
    n_total++; if (wrcount !== 16'h1) $display("FAIL simul_wrcount: got %h want 0001", wrcount); else n_pass++;
  endtask

  task automatic test_saturation();
    reset2 = 1'b0;
    tick();
    memwrite = 1'b1;
    dataadr  = 32'h10;
    writedata = 32'h0;
    repeat (65534) tick();
    n_total++; if (wrcount2 !== 16'hFFFE) $display("FAIL sat_minus1: got %h want fffe", wrcount2); else n_pass++;
    tick();
    n_total++; if (wrcount2 !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", wrcount2); else n_pass++;
    repeat (70000 - 65535) tick();
    memwrite = 1'b0;
    n_total++; if (wrcount2 !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", wrcount2); else n_pass++;
    n_total++; if (done2 !== 1'b0) $display("FAIL sat_done: got %b want 0", done2); else n_pass++;
    #2;
    reset2 = 1'b1;
    #1;
    n_total++; if (leds2 !== 4'b0001) $display("FAIL midrun_reset_leds: got %b want 0001", leds2); else n_pass++;
    n_total++; if (wrcount2 !== 16'h0) $display("FAIL midrun_reset_wrcount: got %h want 0000", wrcount2); else n_pass++;
    n_total++; if (done2 !== 1'b0 || passed2 !== 1'b0) $display("FAIL midrun_reset_flags: got %b%b want 00", done2, passed2); else n_pass++;
    tick();
    reset2 = 1'b0;
    tick();
    n_total++; if (leds2 !== 4'b1001) $display("FAIL rerun_leds: got %b want 1001", leds2); else n_pass++;
    n_total++; if (wrcount2 !== 16'h0) $display("FAIL rerun_wrcount: got %h want 0000", wrcount2); else n_pass++;
  endtask

  initial begin
    #6;
    test_reset();
    test_pass();
    test_fail_data();
    test_timeout();
    test_simultaneous();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
